// File: rtl/dram_wr_arbiter.sv
// Round-robin burst arbiter that shares one DRAM write port between two
// capture writers: forwards len data words, then one region-relocated kick.
module dram_wr_arbiter #(
    parameter logic [31:0] BASE0  = 32'h0000_0000,
    parameter logic [31:0] BASE1  = 32'h0080_0000,
    parameter int          MAXLEN = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] rq0_ctrl,
    input  logic        rq0_valid,
    input  logic [35:0] rq0_data,
    input  logic        rq0_data_valid,
    output logic        rq0_data_ready,
    output logic        rq0_done,
    input  logic [39:0] rq1_ctrl,
    input  logic        rq1_valid,
    input  logic [35:0] rq1_data,
    input  logic        rq1_data_valid,
    output logic        rq1_data_ready,
    output logic        rq1_done,
    output logic [35:0] data_in,
    output logic        data_we,
    output logic [39:0] ctrl_in,
    output logic        ctrl_we,
    input  logic        wr_full,
    output logic        grant,
    output logic        busy
);

    localparam logic [7:0] MAXLEN_B = 8'(MAXLEN);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        KICK,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        gnt_nx;
    logic        last;
    logic        last_nx;
    logic [7:0]  len_q;
    logic [7:0]  len_nx;
    logic [31:0] addr_q;
    logic [31:0] addr_nx;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nx;
    logic [35:0] din_nx;
    logic        dwe_nx;
    logic [39:0] cin_nx;
    logic        cwe_nx;

    logic        pick;
    logic [39:0] req_ctrl;
    logic [7:0]  req_len;
    logic [31:0] req_base;
    logic        sel_valid;
    logic [35:0] sel_data;
    logic        ready;
    logic        xfer;

    // Tie goes to whichever requester was not served last.
    always_comb begin
        pick = 1'b0;
        if (rq0_valid && rq1_valid) begin
            pick = ~last;
        end else begin
            pick = rq1_valid;
        end
    end

    assign req_ctrl = pick ? rq1_ctrl : rq0_ctrl;
    assign req_base = pick ? BASE1 : BASE0;
    assign req_len  = (req_ctrl[39:32] > MAXLEN_B) ? MAXLEN_B
                                                   : req_ctrl[39:32];

    assign sel_valid = grant ? rq1_data_valid : rq0_data_valid;
    assign sel_data  = grant ? rq1_data : rq0_data;
    assign ready     = (state == DATA) && !wr_full;
    assign xfer      = ready && sel_valid;

    assign rq0_data_ready = ready && !grant;
    assign rq1_data_ready = ready && grant;
    assign rq0_done       = (state == DONE) && !grant;
    assign rq1_done       = (state == DONE) && grant;
    assign busy           = (state == DATA) || (state == KICK);

    always_comb begin
        state_nx = state;
        gnt_nx   = grant;
        last_nx  = last;
        len_nx   = len_q;
        addr_nx  = addr_q;
        cnt_nx   = cnt;
        din_nx   = data_in;
        dwe_nx   = 1'b0;
        cin_nx   = ctrl_in;
        cwe_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rq0_valid || rq1_valid) begin
                    gnt_nx   = pick;
                    len_nx   = req_len;
                    addr_nx  = req_ctrl[31:0] + req_base;
                    cnt_nx   = 8'd0;
                    state_nx = (req_len == 8'd0) ? DONE : DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    din_nx = sel_data;
                    dwe_nx = 1'b1;
                    cnt_nx = cnt + 8'd1;
                    if (cnt + 8'd1 == len_q) begin
                        state_nx = KICK;
                    end
                end
            end
            KICK: begin
                if (!wr_full) begin
                    cin_nx   = {len_q, addr_q};
                    cwe_nx   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                last_nx  = grant;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // last resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant   <= 1'b0;
            last    <= 1'b1;
            len_q   <= 8'd0;
            addr_q  <= 32'd0;
            cnt     <= 8'd0;
            data_in <= 36'd0;
            data_we <= 1'b0;
            ctrl_in <= 40'd0;
            ctrl_we <= 1'b0;
        end else begin
            state   <= state_nx;
            grant   <= gnt_nx;
            last    <= last_nx;
            len_q   <= len_nx;
            addr_q  <= addr_nx;
            cnt     <= cnt_nx;
            data_in <= din_nx;
            data_we <= dwe_nx;
            ctrl_in <= cin_nx;
            ctrl_we <= cwe_nx;
        end
    end

endmodule

// File: tb/tb_dram_wr_arbiter.sv
// Scoreboard bench for dram_wr_arbiter: two modelled requesters, data and
// kick streams checked against queues filled as stimulus is issued.
module tb_dram_wr_arbiter;

    localparam logic [31:0] B0 = 32'h0000_0000;
    localparam logic [31:0] B1 = 32'h0080_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [39:0] rq0_ctrl = '0;
    logic        rq0_valid = 1'b0;
    logic [35:0] rq0_data = '0;
    logic        rq0_data_valid = 1'b0;
    logic        rq0_data_ready;
    logic        rq0_done;
    logic [39:0] rq1_ctrl = '0;
    logic        rq1_valid = 1'b0;
    logic [35:0] rq1_data = '0;
    logic        rq1_data_valid = 1'b0;
    logic        rq1_data_ready;
    logic        rq1_done;
    logic [35:0] data_in;
    logic        data_we;
    logic [39:0] ctrl_in;
    logic        ctrl_we;
    logic        wr_full = 1'b0;
    logic        grant;
    logic        busy;

    always #5 clk = ~clk;

    dram_wr_arbiter #(.BASE0(B0), .BASE1(B1), .MAXLEN(64)) dut (
        .clk(clk), .rst(rst),
        .rq0_ctrl(rq0_ctrl), .rq0_valid(rq0_valid),
        .rq0_data(rq0_data), .rq0_data_valid(rq0_data_valid),
        .rq0_data_ready(rq0_data_ready), .rq0_done(rq0_done),
        .rq1_ctrl(rq1_ctrl), .rq1_valid(rq1_valid),
        .rq1_data(rq1_data), .rq1_data_valid(rq1_data_valid),
        .rq1_data_ready(rq1_data_ready), .rq1_done(rq1_done),
        .data_in(data_in), .data_we(data_we),
        .ctrl_in(ctrl_in), .ctrl_we(ctrl_we),
        .wr_full(wr_full), .grant(grant), .busy(busy)
    );

    int n_tests = 0;
    int n_fail = 0;
    int acc_cnt = 0;
    int we_cnt = 0;
    int kick_cnt = 0;
    int done_cnt = 0;

    logic [35:0] src0[$];
    logic [35:0] src1[$];
    logic [35:0] exp_d[$];
    logic [39:0] exp_k[$];
    int          exp_done[$];

    logic acc0 = 1'b0;
    logic acc1 = 1'b0;
    logic fullq = 1'b0;

    always @(posedge clk) begin
        acc0  <= rq0_data_valid && rq0_data_ready;
        acc1  <= rq1_data_valid && rq1_data_ready;
        fullq <= wr_full;
    end

    task automatic check(string tag, logic [79:0] got, logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        rq0_data_valid = (src0.size() > 0);
        rq0_data       = (src0.size() > 0) ? src0[0] : '0;
        rq1_data_valid = (src1.size() > 0);
        rq1_data       = (src1.size() > 0) ? src1[0] : '0;
    endtask

    // One clock: collect accepted words, check outputs, update requesters.
    task automatic tick();
        @(negedge clk);
        if (acc0 && src0.size() > 0) begin
            check("acc_gnt0", 80'(grant), 80'(0));
            exp_d.push_back(src0.pop_front());
            acc_cnt++;
        end
        if (acc1 && src1.size() > 0) begin
            check("acc_gnt1", 80'(grant), 80'(1));
            exp_d.push_back(src1.pop_front());
            acc_cnt++;
        end
        if (data_we) begin
            we_cnt++;
            if (exp_d.size() == 0) check("data_unexp", 80'(data_we), 80'(0));
            else check("data", 80'(data_in), 80'(exp_d.pop_front()));
        end
        if (ctrl_we) begin
            kick_cnt++;
            if (exp_k.size() == 0) check("kick_unexp", 80'(ctrl_we), 80'(0));
            else check("kick", 80'(ctrl_in), 80'(exp_k.pop_front()));
        end
        if (rq0_done || rq1_done) begin
            done_cnt++;
            if (exp_done.size() == 0) check("done_unexp", 80'(1), 80'(0));
            else check("done_id", {rq1_done, rq0_done},
                       (exp_done.pop_front() == 1) ? 80'd2 : 80'd1);
            if (rq0_done) rq0_valid = 1'b0;
            if (rq1_done) rq1_valid = 1'b0;
        end
        if (fullq) check("we_full", {data_we, ctrl_we}, 80'(0));
        drive();
    endtask

    task automatic req(int r, logic [7:0] len, logic [31:0] addr, int nw);
        logic [35:0] w;
        logic [7:0]  el;
        for (int i = 0; i < nw; i++) begin
            w[35:32] = 4'($urandom_range(0, 15));
            w[31:0]  = $urandom();
            if (r == 1) src1.push_back(w);
            else src0.push_back(w);
        end
        el = (len > 8'd64) ? 8'd64 : len;
        if (el != 8'd0) exp_k.push_back({el, addr + ((r == 1) ? B1 : B0)});
        exp_done.push_back(r);
        if (r == 1) begin
            rq1_ctrl  = {len, addr};
            rq1_valid = 1'b1;
        end else begin
            rq0_ctrl  = {len, addr};
            rq0_valid = 1'b1;
        end
        drive();
    endtask

    task automatic drain(string tag, int budget);
        int c;
        c = 0;
        while ((exp_done.size() + exp_k.size() + exp_d.size()) > 0
               && c < budget) begin
            tick();
            c++;
        end
        check(tag, 80'(exp_done.size() + exp_k.size() + exp_d.size()),
              80'(0));
        tick();
    endtask

    initial begin
        int w0;
        int k0;
        int c;
        tick();
        tick();
        check("rst_outs", {data_we, ctrl_we, busy, grant, rq0_done,
              rq1_done, rq0_data_ready, rq1_data_ready}, 80'(0));
        check("rst_bus", {data_in, ctrl_in}, 80'(0));
        rst = 1'b1;
        tick();

        w0 = we_cnt;
        req(0, 8'd4, 32'h100, 4);
        drain("single", 50);
        check("single_we", 80'(we_cnt - w0), 80'(4));

        w0 = we_cnt;
        req(1, 8'd2, 32'h40, 2);
        drain("base", 50);
        check("base_we", 80'(we_cnt - w0), 80'(2));

        w0 = we_cnt;
        k0 = done_cnt;
        for (int rd = 0; rd < 2; rd++) begin
            req(0, 8'd3, 32'h1000 + 32'(rd * 16), 3);
            req(1, 8'd3, 32'h2000 + 32'(rd * 16), 3);
            drain("contend", 100);
        end
        check("contend_we", 80'(we_cnt - w0), 80'(12));
        check("contend_done", 80'(done_cnt - k0), 80'(4));

        w0 = we_cnt;
        k0 = acc_cnt;
        req(0, 8'd6, 32'h200, 6);
        c = 0;
        while (acc_cnt < k0 + 3 && c < 50) begin
            tick();
            c++;
        end
        check("bp_start", 80'(acc_cnt - k0), 80'(3));
        wr_full = 1'b1;
        repeat (5) begin
            tick();
            check("bp_ready", 80'(rq0_data_ready), 80'(0));
        end
        check("bp_hold_cnt", 80'(acc_cnt - k0), 80'(3));
        wr_full = 1'b0;
        c = 0;
        while (!(src0.size() == 1 && rq0_data_valid && rq0_data_ready)
               && c < 50) begin
            tick();
            c++;
        end
        @(posedge clk);
        #1;
        wr_full = 1'b1;
        repeat (5) tick();
        check("bp_kick_hold", 80'(exp_k.size()), 80'(1));
        wr_full = 1'b0;
        drain("bp", 50);
        check("bp_we", 80'(we_cnt - w0), 80'(6));

        w0 = we_cnt;
        k0 = kick_cnt;
        req(0, 8'd0, 32'h300, 0);
        drain("len0", 20);
        check("len0_we", 80'(we_cnt - w0), 80'(0));
        check("len0_kick", 80'(kick_cnt - k0), 80'(0));

        w0 = we_cnt;
        req(0, 8'd200, 32'h4000, 200);
        drain("clamp", 400);
        check("clamp_we", 80'(we_cnt - w0), 80'(64));
        check("clamp_left", 80'(src0.size()), 80'(136));
        src0.delete();
        drive();
        tick();

        k0 = acc_cnt;
        req(1, 8'd4, 32'h500, 4);
        c = 0;
        while (acc_cnt < k0 + 2 && c < 50) begin
            tick();
            c++;
        end
        #2;
        rst = 1'b0;
        #1;
        check("arst_outs", {data_we, ctrl_we, busy, grant, rq0_done,
              rq1_done, rq0_data_ready, rq1_data_ready}, 80'(0));
        check("arst_bus", {data_in, ctrl_in}, 80'(0));
        exp_k.delete();
        exp_done.delete();
        exp_d.delete();
        src1.delete();
        rq1_valid = 1'b0;
        drive();
        k0 = kick_cnt;
        tick();
        tick();
        rst = 1'b1;
        w0 = we_cnt;
        req(0, 8'd2, 32'h600, 2);
        req(1, 8'd2, 32'h700, 2);
        drain("post_rst", 100);
        check("post_rst_kicks", 80'(kick_cnt - k0), 80'(2));
        check("post_rst_we", 80'(we_cnt - w0), 80'(4));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

endmodule

// File: doc/dram_wr_arbiter.md
Name: dram_wr_arbiter

Overview:
Two-requester burst arbiter that shares the single DRAM write port (data word + strobe stream followed by a len/addr kick) between capture sources, e.g. two video-to-DRAM writers.
- Grants one requester per burst, round-robin.
- Forwards exactly len data words, then one kick with the requester's region base added to the address.
- Honours downstream backpressure.
- Sits between the capture writers and the DRAM write controller, in the same clock domain as the writers.

Parameters:
BASE0, 32'h0000_0000, byte base address added to requester 0 kick addresses
BASE1, 32'h0080_0000, byte base address added to requester 1 kick addresses
MAXLEN, 64, largest legal burst length in words; longer requests are clamped

Ports:
clk  in  1  block clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
rq0_ctrl  in  40  requester 0 burst descriptor: len[39:32] + addr[31:0]
rq0_valid  in  1  requester 0 descriptor valid, held until rq0_done
rq0_data  in  36  requester 0 data word: strb[35:32] + data[31:0]
rq0_data_valid  in  1  requester 0 data word valid
rq0_data_ready  out  1  requester 0 data word accepted this cycle
rq0_done  out  1  one-cycle pulse: requester 0 burst completed
rq1_ctrl  in  40  as rq0_ctrl, requester 1
rq1_valid  in  1  as rq0_valid
rq1_data  in  36  as rq0_data
rq1_data_valid  in  1  as rq0_data_valid
rq1_data_ready  out  1  as rq0_data_ready
rq1_done  out  1  as rq0_done
data_in  out  36  DRAM write data: strb[35:32] + data[31:0]
data_we  out  1  data_in write enable
ctrl_in  out  40  DRAM kick: len[39:32] + addr[31:0]
ctrl_we  out  1  ctrl_in write enable
wr_full  in  1  downstream full; no data_we or ctrl_we is issued while high
grant  out  1  index of requester owning the port (valid when busy)
busy  out  1  a burst is in progress

Behaviour:
Reset (rst low, asynchronous):
- All outputs 0; data_in/ctrl_in 0; state IDLE.
- Round-robin pointer set so requester 0 wins the first tie.
- Reset mid-burst abandons the burst; no kick is emitted.

State IDLE:
- Only one requester valid: grant it.
- Both valid: grant the requester that was not granted last.
- On grant: latch len = min(ctrl[39:32], MAXLEN); latch addr = ctrl[31:0] + BASEg (32-bit wrap, no carry out); clear word count; busy=1; go to DATA next cycle.
- Latched len == 0: go to DONE and skip DATA/KICK.

State DATA:
- rqg_data_ready = !wr_full; combinational, same cycle.
- Transfer occurs when rqg_data_valid && rqg_data_ready.
- On transfer, next cycle: data_in = rqg_data, data_we = 1, count+1.
- Otherwise data_we = 0 next cycle.
- Non-granted requester's data_ready = 0 always.
- On the transfer where count reaches len: go to KICK.

State KICK:
- When !wr_full: ctrl_in = {len, latched addr}, ctrl_we = 1 for one cycle, go to DONE.
- When wr_full: wait; ctrl_we stays 0.

State DONE:
- rqg_done = 1 for one cycle; update round-robin pointer to g.
- busy = 0; go to IDLE.
- The requester drops or replaces rqg_valid after seeing done.
- A requester still valid in the following IDLE cycle is treated as a new request.

Timing and rules:
- Latency: a data word is accepted in cycle N and data_we is asserted in cycle N+1.
- The kick is registered one cycle after the last data_we at the earliest.
- Minimum burst overhead: IDLE + KICK + DONE = 3 cycles, in addition to one cycle per word.
- Descriptor changes while granted are ignored; values are latched at grant.
- Lengths wider than MAXLEN are clamped; the excess data words stay with the requester.
- A requester whose valid drops mid-burst still owns the port until len words have been transferred.
- Grant changes only in IDLE; bursts never interleave.

Test Plan:
- Single burst: rq0 ctrl={8'd4,32'h100}, 4 words, wr_full=0 -> 4 data_we pulses with matching data in order, then ctrl_in={8'd4,32'h100}, ctrl_we=1, then rq0_done pulse.
- Base offset: rq1 ctrl={8'd2,32'h40} -> ctrl_in={8'd2,32'h0080_0040}.
- Contention: rq0 and rq1 valid from the same cycle, len 3 each, repeated -> grant order 0,1,0,1; no data interleave; done pulses alternate.
- Backpressure: wr_full=1 for 5 cycles mid-DATA and at KICK -> data_ready=0, no data_we or ctrl_we while full; word count and kick value unchanged after release.
- Edge lengths: len=0 -> no data_we, no ctrl_we, done pulse; len=200 with MAXLEN=64 -> exactly 64 data_we, kick len=8'd64.
- Async reset: assert rst low after 2 of 4 words -> all outputs 0 immediately; no kick; after release, next request starts cleanly with requester 0 priority.
